// File: rtl/div_pkg.sv
// Shared types and sizing for the multi-cycle restoring divider.
// Holds the FSM state encoding, the default operand width and the step-counter width.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } div_state_t;

  localparam int DIV_WIDTH = 32;

  // The counter reaches WIDTH at most, so it needs clog2(WIDTH+1) bits.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int DIV_CNT_W = cnt_width(DIV_WIDTH);

endpackage

// File: rtl/div_unit_if.sv
// Request/result bundle between the execute stage and the divider.
// master = pipeline side, slave = divider side.
interface div_unit_if import div_pkg::*; #(parameter int WIDTH = DIV_WIDTH) ();

  logic             start;
  logic             signed_op;
  logic             cancel;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, signed_op, cancel, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, signed_op, cancel, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/div_step.sv
// One restoring-division step: WIDTH+1 bit trial subtraction of the divisor
// from the shifted partial remainder, returning the difference and the borrow.
module div_step import div_pkg::*; #(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   partial,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  logic [WIDTH+1:0] full;

  assign full = {1'b0, partial} - {2'b00, divisor};
  assign diff = full[WIDTH-1:0];
  // A non-borrowing difference is always below the divisor, so bit WIDTH is
  // only ever set alongside the true borrow; folding it in leaves the flag exact.
  assign borrow = full[WIDTH+1] | full[WIDTH];

endmodule

// File: rtl/div_unit.sv
// Multi-cycle restoring divider producing quotient/remainder for HI/LO.
// Signed DIV support is compiled in only when DIV_SIGNED_EN is defined.
//
// state | meaning
// IDLE  | waiting for start; results held
// CALC  | one restoring step per cycle, WIDTH steps
// FIX   | sign correction, register results, pulse done
module div_unit import div_pkg::*; #(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic       clk,
  input  logic       resetn,
  div_unit_if.slave  bus
);

  localparam int CNT_W = cnt_width(WIDTH);

  div_state_t       state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo_sh;
  logic [WIDTH-1:0] dsr_mag;
  logic             dz_op;
  logic             load, step_en, fix_en, busy_w;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] q_fix, r_fix;
  logic [WIDTH:0]   step_in;
  logic [WIDTH-1:0] step_diff;
  logic             step_borrow;

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (bus.start && !bus.cancel)
              state_nx = (bus.divisor == '0) ? FIX : CALC;
      CALC: if (bus.cancel)                        state_nx = IDLE;
            else if (cnt == CNT_W'(WIDTH - 1))     state_nx = FIX;
      FIX:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    load    = 1'b0;
    step_en = 1'b0;
    fix_en  = 1'b0;
    busy_w  = (state != IDLE);
    case (state)
      IDLE:    load    = bus.start & ~bus.cancel;
      CALC:    step_en = ~bus.cancel;
      FIX:     fix_en  = ~bus.cancel;
      default: ;
    endcase
  end

  assign bus.busy = busy_w;

`ifdef DIV_SIGNED_EN
  logic a_neg, b_neg, neg_q, neg_r;
  logic [WIDTH-1:0] r_src;

  assign a_neg = bus.signed_op & bus.dividend[WIDTH-1];
  assign b_neg = bus.signed_op & bus.divisor[WIDTH-1];
  assign a_mag = a_neg ? -bus.dividend : bus.dividend;
  assign b_mag = b_neg ? -bus.divisor  : bus.divisor;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (load) begin
      neg_q <= a_neg ^ b_neg;
      neg_r <= a_neg;
    end
  end

  // On divide-by-zero the dividend magnitude is still parked in quo_sh.
  assign r_src = dz_op ? quo_sh : rem;
  assign q_fix = dz_op ? '1 : (neg_q ? -quo_sh : quo_sh);
  assign r_fix = neg_r ? -r_src : r_src;
`else
  assign a_mag = bus.dividend;
  assign b_mag = bus.divisor;
  assign q_fix = dz_op ? '1 : quo_sh;
  assign r_fix = dz_op ? quo_sh : rem;
`endif

  assign step_in = {rem, quo_sh[WIDTH-1]};

  div_step #(.WIDTH(WIDTH)) u_step (
    .partial (step_in),
    .divisor (dsr_mag),
    .diff    (step_diff),
    .borrow  (step_borrow)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rem     <= '0;
      quo_sh  <= '0;
      dsr_mag <= '0;
      cnt     <= '0;
      dz_op   <= 1'b0;
    end else if (load) begin
      rem     <= '0;
      quo_sh  <= a_mag;
      dsr_mag <= b_mag;
      cnt     <= '0;
      dz_op   <= (bus.divisor == '0);
    end else if (step_en) begin
      rem     <= step_borrow ? step_in[WIDTH-1:0] : step_diff;
      quo_sh  <= {quo_sh[WIDTH-2:0], ~step_borrow};
      cnt     <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      bus.done        <= 1'b0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.div_by_zero <= 1'b0;
    end else begin
      bus.done <= fix_en;
      if (fix_en) begin
        bus.quotient    <= q_fix;
        bus.remainder   <= r_fix;
        bus.div_by_zero <= dz_op;
      end
    end
  end

endmodule
